// File: rtl/fifo_write_arbiter.sv
// Round-robin, credit-aware arbiter sharing the credit FIFO write port among
// NUM_REQ requesters; grants bursts of up to MAX_BURST beats in the re_clk domain.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 10,
    parameter int MAX_BURST = 8,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     re_clk,
    input  logic                     re_reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_mask,
    input  logic [ADDR_W:0]          fifo_credit,
    output logic                     fifo_valid,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic                     burst_done
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rr_last_q, rr_last_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [WIDTH-1:0]   req_arr [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    cand_id;
    logic               found;
    logic               xfer;
    logic               last_beat;
    int                 cand;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Search upward with wrap, starting just after the last completed grant.
    always_comb begin
        eligible = req_valid & ~req_mask;
        found    = 1'b0;
        pick     = '0;
        cand     = 0;
        cand_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand    = (int'(rr_last_q) + k) % NUM_REQ;
            cand_id = ID_W'(cand);
            if (!found && eligible[cand_id]) begin
                found = 1'b1;
                pick  = cand_id;
            end
        end
    end

    // Handshake: a beat moves in any cycle where the granted requester holds
    // req_valid and the FIFO reports non-zero credit; req_ready, fifo_valid and
    // fifo_data are all asserted together, combinationally, in exactly that cycle.
    always_comb begin
        xfer      = (state_q == BURST) && req_valid[grant_id_q] && (fifo_credit != '0);
        last_beat = req_last[grant_id_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1));
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (last_beat) begin
                        rr_last_d = grant_id_q;
                        state_d   = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge re_clk or negedge re_reset_n) begin
        if (!re_reset_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_last_q  <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        fifo_valid = xfer;
        fifo_data  = xfer ? req_arr[grant_id_q] : '0;
        req_ready  = xfer ? (NUM_REQ'(1) << grant_id_q) : '0;
        burst_done = xfer && last_beat;
        busy       = (state_q == BURST);
        grant_id   = grant_id_q;
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, round-robin, burst cap, credit
// stall, masking and mid-burst reset, each checked against hand-computed values.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int AW = 10;

    logic            re_clk;
    logic            re_reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_mask;
    logic [AW:0]     fifo_credit;
    logic            fifo_valid;
    logic [W-1:0]    fifo_data;
    logic [1:0]      grant_id;
    logic            busy;
    logic            burst_done;

    int total = 0;
    int bad   = 0;
    int bc [NR];
    int last_len [NR];
    logic [W-1:0] exp_q [$];

    fifo_write_arbiter dut (
        .re_clk      (re_clk),
        .re_reset_n  (re_reset_n),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .req_mask    (req_mask),
        .fifo_credit (fifo_credit),
        .fifo_valid  (fifo_valid),
        .fifo_data   (fifo_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .burst_done  (burst_done)
    );

    initial begin
        re_clk = 1'b0;
        forever #5 re_clk = ~re_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] exp_data(input int id, input int beat);
        return W'((id << 16) | beat);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NR; i++) begin
            req_data[i*W +: W] = exp_data(i, bc[i]);
            req_last[i] = 1'b0;
            if (last_len[i] != 0) begin
                req_last[i] = ((bc[i] % last_len[i]) == (last_len[i] - 1));
            end
        end
    endtask

    // Requester-side driver: advance a requester's beat index when its beat was accepted.
    task automatic adv();
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) bc[i]++;
        end
        @(posedge re_clk);
        #1;
        drive_data();
    endtask

    task automatic do_reset();
        re_reset_n  = 1'b0;
        req_valid   = '0;
        req_mask    = '0;
        fifo_credit = 11'd100;
        for (int i = 0; i < NR; i++) begin
            bc[i]       = 0;
            last_len[i] = 0;
        end
        drive_data();
        repeat (2) @(posedge re_clk);
        #1;
        re_reset_n = 1'b1;
    endtask

    initial begin
        int done_cnt;
        int ph;
        int id;
        int rnd;
        int cap_beats;
        int cr [13];
        logic [W-1:0] got;
        logic exp_v;
        int exp_g;

        // ---- reset defaults
        re_reset_n  = 1'b0;
        req_valid   = '0;
        req_mask    = '0;
        fifo_credit = '0;
        for (int i = 0; i < NR; i++) begin
            bc[i]       = 0;
            last_len[i] = 0;
        end
        drive_data();
        repeat (2) @(posedge re_clk);
        #1;
        chk("rst_fifo_valid", 32'(fifo_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_fifo_data", fifo_data, 32'd0);
        chk("rst_burst_done", 32'(burst_done), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge re_clk);
            chk("idle_fifo_valid", 32'(fifo_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_grant_id", 32'(grant_id), 32'd0);
            adv();
        end

        // ---- round-robin: four requesters, 3-beat bursts, one bubble each
        do_reset();
        for (int i = 0; i < NR; i++) last_len[i] = 3;
        fifo_credit = 11'd100;
        req_valid   = 4'hf;
        drive_data();
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge re_clk);
            ph  = c % 4;
            id  = (c / 4) % 4;
            rnd = c / 16;
            if (ph == 0) begin
                chk("rr_bubble_valid", 32'(fifo_valid), 32'd0);
                chk("rr_bubble_busy", 32'(busy), 32'd0);
            end else begin
                chk("rr_valid", 32'(fifo_valid), 32'd1);
                chk("rr_grant", 32'(grant_id), 32'(id));
                chk("rr_ready", 32'(req_ready), 32'(1 << id));
                chk("rr_data", fifo_data, exp_data(id, rnd * 3 + ph - 1));
                chk("rr_done", 32'(burst_done), 32'(ph == 3));
            end
            done_cnt += int'(burst_done);
            if (c == 15) chk("rr_done_count_16", 32'(done_cnt), 32'd4);
            adv();
        end
        req_valid = '0;

        // ---- burst cap: requester 1 never sends last, requester 2 waits
        do_reset();
        last_len[2] = 1;
        fifo_credit = 11'h400;
        req_valid   = 4'b0110;
        drive_data();
        cap_beats = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge re_clk);
            exp_v = ((c >= 1) && (c <= 8)) || (c == 10);
            exp_g = (c == 0) ? 0 : ((c <= 9) ? 1 : 2);
            chk("cap_valid", 32'(fifo_valid), 32'(exp_v));
            chk("cap_grant", 32'(grant_id), 32'(exp_g));
            chk("cap_busy", 32'(busy), 32'((c >= 1) && (c != 9)));
            chk("cap_done", 32'(burst_done), 32'((c == 8) || (c == 10)));
            chk("cap_ready", 32'(req_ready), exp_v ? 32'(1 << exp_g) : 32'd0);
            if (exp_v) begin
                chk("cap_data", fifo_data, (c <= 8) ? exp_data(1, c - 1) : exp_data(2, 0));
            end
            if (fifo_valid && grant_id == 2'd1) cap_beats++;
            adv();
        end
        chk("cap_beats_req1", 32'(cap_beats), 32'd8);
        req_valid = '0;

        // ---- credit stall: 6-beat burst, credit 2 / 0 x5 / 4
        do_reset();
        last_len[0] = 6;
        req_valid   = 4'b0001;
        drive_data();
        cr = '{2, 2, 2, 0, 0, 0, 0, 0, 4, 4, 4, 4, 4};
        for (int b = 0; b < 6; b++) exp_q.push_back(exp_data(0, b));
        for (int c = 0; c < 13; c++) begin
            fifo_credit = 11'(cr[c]);
            @(negedge re_clk);
            exp_v = ((c >= 1) && (c <= 2)) || ((c >= 8) && (c <= 11));
            chk("stall_valid", 32'(fifo_valid), 32'(exp_v));
            chk("stall_busy", 32'(busy), 32'((c >= 1) && (c <= 11)));
            chk("stall_done", 32'(burst_done), 32'(c == 11));
            if (fifo_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stall_extra_beat", 32'd1, 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    chk("stall_data", fifo_data, got);
                end
            end
            adv();
        end
        chk("stall_all_beats", 32'(exp_q.size()), 32'd0);
        req_valid = '0;

        // ---- mask 0101: only 1 and 3 granted
        do_reset();
        for (int i = 0; i < NR; i++) last_len[i] = 1;
        req_mask  = 4'b0101;
        req_valid = 4'hf;
        drive_data();
        for (int c = 0; c < 6; c++) begin
            @(negedge re_clk);
            exp_g = (c == 3) ? 3 : 1;
            chk("mask_valid", 32'(fifo_valid), 32'(c % 2));
            if (c % 2 == 1) begin
                chk("mask_grant", 32'(grant_id), 32'(exp_g));
                chk("mask_ready", 32'(req_ready), 32'(1 << exp_g));
            end
            adv();
        end

        // ---- masking the granted requester mid-burst
        do_reset();
        last_len[1] = 3;
        last_len[3] = 1;
        req_valid   = 4'b1010;
        drive_data();
        for (int c = 0; c < 6; c++) begin
            @(negedge re_clk);
            exp_v = (c >= 1) && (c != 4);
            exp_g = (c == 0) ? 0 : ((c == 5) ? 3 : 1);
            chk("mmask_valid", 32'(fifo_valid), 32'(exp_v));
            chk("mmask_grant", 32'(grant_id), 32'(exp_g));
            chk("mmask_done", 32'(burst_done), 32'((c == 3) || (c == 5)));
            if (c == 1) req_mask = 4'b0010;
            adv();
        end
        req_valid = '0;

        // ---- reset asserted on beat 2 of a burst from requester 2
        do_reset();
        req_valid = 4'b0100;
        drive_data();
        @(negedge re_clk);
        chk("mrst_idle_busy", 32'(busy), 32'd0);
        adv();
        @(negedge re_clk);
        chk("mrst_beat1_valid", 32'(fifo_valid), 32'd1);
        chk("mrst_beat1_grant", 32'(grant_id), 32'd2);
        adv();
        @(negedge re_clk);
        chk("mrst_beat2_data", fifo_data, exp_data(2, 1));
        #1;
        re_reset_n = 1'b0;
        #1;
        chk("mrst_async_valid", 32'(fifo_valid), 32'd0);
        chk("mrst_async_ready", 32'(req_ready), 32'd0);
        chk("mrst_async_data", fifo_data, 32'd0);
        chk("mrst_async_busy", 32'(busy), 32'd0);
        chk("mrst_async_done", 32'(burst_done), 32'd0);
        chk("mrst_async_grant", 32'(grant_id), 32'd0);
        for (int i = 0; i < NR; i++) bc[i] = 0;
        req_valid = 4'b0101;
        drive_data();
        @(posedge re_clk);
        #1;
        re_reset_n = 1'b1;
        @(negedge re_clk);
        chk("mrst_post_busy", 32'(busy), 32'd0);
        chk("mrst_post_valid", 32'(fifo_valid), 32'd0);
        adv();
        @(negedge re_clk);
        chk("mrst_regrant_id", 32'(grant_id), 32'd0);
        chk("mrst_regrant_valid", 32'(fifo_valid), 32'd1);
        chk("mrst_regrant_data", fifo_data, exp_data(0, 0));
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
